// File: rtl/mem_log_reader.sv
// mem_log_reader: once the sample log is full, reads every word back through
// the logger read port and streams it out as an I byte then a Q byte on a
// valid/ready byte interface toward the serial transmitter.
module mem_log_reader #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16,
    parameter int RD_LATENCY      = 1
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic                       i_mem_full,
    input  logic                       i_start,
    input  logic [BRAM_DATA_WIDTH-1:0] i_data_log_from_mem,
    input  logic                       i_ready,
    output logic                       o_read_log,
    output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem,
    output logic [7:0]                 o_data,
    output logic                       o_valid,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_abort
);

    // The latency counter runs 0..RD_LATENCY inside ADDR, so ADDR lasts
    // RD_LATENCY+1 cycles: one for the address to reach the logger and
    // RD_LATENCY for the read data to come back.
    localparam int                CNT_W    = $clog2(RD_LATENCY + 2);
    localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(RD_LATENCY);
    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = BRAM_ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        SEND_HI,
        SEND_LO,
        DONE
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [BRAM_ADDR_WIDTH-1:0] addr;
    logic [BRAM_DATA_WIDTH-1:0] word;
    logic [CNT_W-1:0]           lat_cnt;
    logic                       abort_q;
    logic                       dumping;
    logic                       abort_now;
    logic                       addr_last;
    logic                       lat_done;

    // A dump is cancelled whenever the logger leaves the full state while we
    // still depend on its contents (everything except IDLE and DONE).
    always_comb begin
        dumping   = (state == REQ) || (state == ADDR) ||
                    (state == SEND_HI) || (state == SEND_LO);
        abort_now = dumping && !i_mem_full;
        addr_last = &addr;
        lat_done  = (lat_cnt == LAT_LAST);
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start && i_mem_full) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                state_next = ADDR;
            end
            ADDR: begin
                if (lat_done) begin
                    state_next = SEND_HI;
                end
            end
            SEND_HI: begin
                if (i_ready) begin
                    state_next = SEND_LO;
                end
            end
            SEND_LO: begin
                if (i_ready) begin
                    state_next = addr_last ? DONE : ADDR;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort_now) begin
            state_next = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Address register: cleared on a new dump, stepped only after the low byte
    // of a word is accepted, and never stepped past all ones.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr <= '0;
        end else if (state == IDLE && i_start && i_mem_full) begin
            addr <= '0;
        end else if (state == SEND_LO && i_ready && !addr_last && !abort_now) begin
            addr <= addr + ADDR_ONE;
        end
    end

    // Latency counter: counts while remaining in ADDR, otherwise held at zero.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lat_cnt <= '0;
        end else if (state == ADDR && state_next == ADDR) begin
            lat_cnt <= lat_cnt + CNT_W'(1);
        end else begin
            lat_cnt <= '0;
        end
    end

    // Word register: captures the read data on the last ADDR cycle.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word <= '0;
        end else if (state == ADDR && lat_done) begin
            word <= i_data_log_from_mem;
        end
    end

    // Abort pulse appears in the first IDLE cycle after a cancelled dump.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= abort_now;
        end
    end

    // Outputs decoded from state so reset forces them low immediately.
    always_comb begin
        o_read_log        = dumping;
        o_addr_log_to_mem = addr;
        o_busy            = (state != IDLE);
        o_done            = (state == DONE);
        o_abort           = abort_q;
        o_valid           = 1'b0;
        o_data            = 8'h00;
        if (state == SEND_HI) begin
            o_valid = 1'b1;
            o_data  = word[BRAM_DATA_WIDTH-1 -: 8];
        end else if (state == SEND_LO) begin
            o_valid = 1'b1;
            o_data  = word[7:0];
        end
    end

endmodule
